// File: rtl/wave_cfg_ctrl.sv
// wave_cfg_ctrl -- UART frame receiver that configures a photon wave generator.
//
// A frame is HEADER, seven payload bytes, then a modulo-256 checksum of the
// payload. A good frame is held in a shadow register. The controller then waits
// for the generator to finish its burst (or for the drain timeout). After that
// it updates the live configuration in one cycle and re-enables the generator.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous, active-low reset
//   rx_byte/rx_valid received UART byte with its one-cycle strobe
//   gen_busy        generator is mid-burst; configuration must not change
//   gen_enable      run enable to the generator
//   cfg_*           live configuration (full width, detect eff, dead time,
//                   clock select, pulse count)
//   cfg_load        one-cycle pulse: cfg_* changed this cycle
//   frame_ok        one-cycle pulse, coincident with cfg_load
//   frame_err       one-cycle pulse on any error
//   err_code        last error: 0 none, 1 checksum, 2 timeout, 3 overrun
//   state_led       [2:0] state code, [3] sticky error flag
module wave_cfg_ctrl #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        gen_busy,
  output logic        gen_enable,
  output logic [15:0] cfg_full_width,
  output logic [7:0]  cfg_detect_eff,
  output logic [7:0]  cfg_deadtime,
  output logic [7:0]  cfg_clk_sel,
  output logic [15:0] cfg_count,
  output logic        cfg_load,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [3:0]  state_led
);

  localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

  // The encodings are the LED codes, so state_led[2:0] is the state register.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3,
    S_DRAIN   = 3'd4,
    S_LOAD    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [6:0][7:0]  shadow_q, shadow_d;
  logic [15:0]      fw_q, fw_d, count_q, count_d;
  logic [7:0]       deff_q, deff_d, dead_q, dead_d, csel_q, csel_d;
  logic             gen_enable_q, gen_enable_d;
  logic             cfg_load_q, cfg_load_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             err_flag_q, err_flag_d;
  logic             err_set;
  logic [1:0]       err_val;
  logic             timed_out;

  // One counter serves two purposes. In PAYLOAD/CHECK it measures silence between
  // bytes. In DRAIN it measures how long gen_busy has been held.
  assign timed_out = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every variable gets a default here, so no path can infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    fw_d         = fw_q;
    deff_d       = deff_q;
    dead_d       = dead_q;
    csel_d       = csel_q;
    count_d      = count_q;
    gen_enable_d = gen_enable_q;
    cfg_load_d   = 1'b0;
    frame_ok_d   = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    err_flag_d   = err_flag_q;
    err_set      = 1'b0;
    err_val      = 2'd0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_byte == HEADER) begin
          state_d = S_PAYLOAD;
          idx_d   = 3'd0;
          sum_d   = 8'd0;
          cnt_d   = '0;
        end
      end

      S_PAYLOAD: begin
        if (rx_valid) begin
          shadow_d[idx_q] = rx_byte;
          sum_d           = sum_q + rx_byte;
          idx_d           = idx_q + 3'd1;
          cnt_d           = '0;
          if (idx_q == 3'd6) state_d = S_CHECK;
        end else if (timed_out) begin
          state_d = S_IDLE;
          err_set = 1'b1;
          err_val = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_CHECK: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (rx_byte == sum_q) begin
            state_d      = S_DRAIN;
            gen_enable_d = 1'b0;
          end else begin
            state_d = S_IDLE;
            err_set = 1'b1;
            err_val = ERR_CHECKSUM;
          end
        end else if (timed_out) begin
          state_d = S_IDLE;
          err_set = 1'b1;
          err_val = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DRAIN: begin
        // A byte arriving here is dropped. It does not restart the drain timer.
        if (rx_valid) begin
          err_set = 1'b1;
          err_val = ERR_OVERRUN;
        end
        if (!gen_busy || timed_out) begin
          state_d    = S_LOAD;
          fw_d       = {shadow_q[0], shadow_q[1]};
          deff_d     = shadow_q[2];
          dead_d     = shadow_q[3];
          csel_d     = shadow_q[4];
          count_d    = {shadow_q[5], shadow_q[6]};
          cfg_load_d = 1'b1;
          frame_ok_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_LOAD: begin
        if (rx_valid) begin
          err_set = 1'b1;
          err_val = ERR_OVERRUN;
        end
        state_d      = S_IDLE;
        gen_enable_d = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    if (frame_ok_d) begin
      err_code_d = 2'd0;
      err_flag_d = 1'b0;
    end
    // If an overrun and a successful load land on the same edge, the error wins.
    if (err_set) begin
      frame_err_d = 1'b1;
      err_code_d  = err_val;
      err_flag_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      sum_q        <= 8'd0;
      cnt_q        <= '0;
      // NOTE: the shadow is only seven bytes of flops, so it is reset along with
      // everything else.
      shadow_q     <= '0;
      fw_q         <= 16'd0;
      deff_q       <= 8'd0;
      dead_q       <= 8'd0;
      csel_q       <= 8'd0;
      count_q      <= 16'd0;
      gen_enable_q <= 1'b0;
      cfg_load_q   <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= 2'd0;
      err_flag_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop see pre-edge values.
      state_q      <= state_d;
      idx_q        <= idx_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      fw_q         <= fw_d;
      deff_q       <= deff_d;
      dead_q       <= dead_d;
      csel_q       <= csel_d;
      count_q      <= count_d;
      gen_enable_q <= gen_enable_d;
      cfg_load_q   <= cfg_load_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      err_flag_q   <= err_flag_d;
    end
  end

  assign gen_enable     = gen_enable_q;
  assign cfg_full_width = fw_q;
  assign cfg_detect_eff = deff_q;
  assign cfg_deadtime   = dead_q;
  assign cfg_clk_sel    = csel_q;
  assign cfg_count      = count_q;
  assign cfg_load       = cfg_load_q;
  assign frame_ok       = frame_ok_q;
  assign frame_err      = frame_err_q;
  assign err_code       = err_code_q;
  assign state_led      = {err_flag_q, state_q};

endmodule
